ones_window_ctrl: RTL and testbench



---
 rtl/ones_window_ctrl_pkg.sv | 27 ++
 rtl/ones_window_ctrl_if.sv | 31 +++
 rtl/ones_window_ctrl_sat_up_counter.sv | 47 ++++
 rtl/ones_window_ctrl.sv | 143 ++++++++++++++
 tb/tb_ones_window_ctrl.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ones_window_ctrl_pkg.sv
// ones_ctrl_pkg
// Shared types and helpers for the ones-counting window controller.
//   state_t      : controller FSM states (IDLE, COUNT, DONE)
//   idx_width()  : bit index width able to hold 0..win_len
//   sat_max()    : saturation ceiling of an unsigned counter of a given width
package ones_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIN_LEN = 8;
  localparam int DEFAULT_CNT_W   = 4;
  // The index runs up to WIN_LEN, so one extra value beyond the last bit.
  localparam int DEFAULT_IDX_W   = $clog2(DEFAULT_WIN_LEN + 1);

  function automatic int idx_width(input int win_len);
    return $clog2(win_len + 1);
  endfunction

  function automatic logic [31:0] sat_max(input int width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/ones_window_ctrl_if.sv
// ones_window_ctrl_if
// Bundles the window request, serial bit stream and result handshake.
//   master : bit source / result consumer (drives start, abort, bit_in,
//            bit_valid, result_ready; observes result, result_valid, busy,
//            overflow)
//   slave  : the controller (mirror image of master)
interface ones_window_ctrl_if #(
  parameter int CNT_W = 4
);

  logic             start;
  logic             abort;
  logic             bit_in;
  logic             bit_valid;
  logic [CNT_W-1:0] result;
  logic             result_valid;
  logic             result_ready;
  logic             busy;
  logic             overflow;

  modport master (
    output start, abort, bit_in, bit_valid, result_ready,
    input  result, result_valid, busy, overflow
  );

  modport slave (
    input  start, abort, bit_in, bit_valid, result_ready,
    output result, result_valid, busy, overflow
  );

endinterface

// File: rtl/ones_window_ctrl_sat_up_counter.sv
// sat_up_counter
// Unsigned up counter that saturates at 2^CNT_W-1 and never wraps.
//   clk   : clock
//   reset : asynchronous active-low reset, clears the count
//   clr   : synchronous clear (wins over inc)
//   inc   : increment request
//   count : current count
//   sat   : combinational pulse when an increment is attempted at the ceiling
module sat_up_counter
  import ones_ctrl_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(sat_max(CNT_W));

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != MAX_CNT)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign sat   = inc && !clr && (count_q == MAX_CNT);

endmodule

// File: rtl/ones_window_ctrl.sv
// ones_window_ctrl
// Opens a window on start, counts the ones among exactly WIN_LEN qualified
// bits (saturating), then offers the count on a valid/ready handshake.
//   clk   : clock
//   reset : asynchronous active-low reset
//   bus   : ones_window_ctrl_if.slave
//           start/abort       window control (abort beats start/completion)
//           bit_in/bit_valid  serial data and its qualifier
//           result/overflow   count and saturation flag of the last window
//           result_valid/ready result handshake
//           busy              window open
module ones_window_ctrl
  import ones_ctrl_pkg::*;
#(
  parameter int WIN_LEN = 8,
  parameter int CNT_W   = 4
) (
  input logic                clk,
  input logic                reset,
  ones_window_ctrl_if.slave  bus
);

  localparam int               IDX_W    = idx_width(WIN_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN_LEN - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] result_q, result_d;
  logic             overflow_q, overflow_d;
  logic             result_valid_q, result_valid_d;
  logic             busy_q, busy_d;

  logic             cnt_clr;
  logic             cnt_inc;
  logic [CNT_W-1:0] count;
  logic             sat;
  logic             take_bit;
  logic [CNT_W-1:0] count_final;
  logic             ovf_final;

  sat_up_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (count),
    .sat   (sat)
  );

  // A bit is taken only inside an open window and never in an abort cycle.
  // count_final / ovf_final are the values after including this cycle's bit,
  // which is what gets captured when the last bit closes the window.
  always_comb begin
    take_bit    = (state_q == COUNT) && bus.bit_valid && !bus.abort;
    cnt_inc     = take_bit && bus.bit_in;
    count_final = (cnt_inc && !sat) ? count + CNT_W'(1) : count;
    ovf_final   = ovf_q | sat;
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ovf_d      = ovf_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    cnt_clr    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d = COUNT;
          idx_d   = '0;
          ovf_d   = 1'b0;
          cnt_clr = 1'b1;
        end
      end

      COUNT: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.bit_valid) begin
          idx_d = idx_q + IDX_W'(1);
          ovf_d = ovf_final;
          if (idx_q == LAST_IDX) begin
            state_d    = DONE;
            result_d   = count_final;
            overflow_d = ovf_final;
          end
        end
      end

      DONE: begin
        // Accepting with start held chains straight into the next window.
        if (bus.result_ready) begin
          if (bus.start && !bus.abort) begin
            state_d = COUNT;
            idx_d   = '0;
            ovf_d   = 1'b0;
            cnt_clr = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d         = (state_d == COUNT);
    result_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      ovf_q          <= 1'b0;
      result_q       <= '0;
      overflow_q     <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      ovf_q          <= ovf_d;
      result_q       <= result_d;
      overflow_q     <= overflow_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
    end
  end

  assign bus.result       = result_q;
  assign bus.overflow     = overflow_q;
  assign bus.result_valid = result_valid_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_ones_window_ctrl.sv
// tb_ones_window_ctrl
// Directed bench for three builds of ones_window_ctrl: WIN_LEN=8, WIN_LEN=20
// and WIN_LEN=1, all with CNT_W=4, sharing one clock and one reset.
module tb_ones_window_ctrl;

  logic clk;
  logic reset;

  int tests;
  int fails;

  ones_window_ctrl_if #(.CNT_W(4)) bus8  ();
  ones_window_ctrl_if #(.CNT_W(4)) bus20 ();
  ones_window_ctrl_if #(.CNT_W(4)) bus1  ();

  ones_window_ctrl #(.WIN_LEN(8),  .CNT_W(4)) dut8  (.clk(clk), .reset(reset), .bus(bus8));
  ones_window_ctrl #(.WIN_LEN(20), .CNT_W(4)) dut20 (.clk(clk), .reset(reset), .bus(bus20));
  ones_window_ctrl #(.WIN_LEN(1),  .CNT_W(4)) dut1  (.clk(clk), .reset(reset), .bus(bus1));

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    tests++; if (bus8.result !== 4'd0) begin fails++; $display("[TB] FAIL reset_result8: got %0d expected 0", bus8.result); end
    tests++; if (bus8.result_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid8: got %0b expected 0", bus8.result_valid); end
    tests++; if (bus8.busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy8: got %0b expected 0", bus8.busy); end
    tests++; if (bus8.overflow !== 1'b0) begin fails++; $display("[TB] FAIL reset_ovf8: got %0b expected 0", bus8.overflow); end
    tests++; if (bus20.busy !== 1'b0 || bus1.busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy_other: got %0b/%0b expected 0/0", bus20.busy, bus1.busy); end
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_basic_window();
    logic [7:0] pat;
    pat = 8'b1011_0110;
    bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    tests++; if (bus8.busy !== 1'b1) begin fails++; $display("[TB] FAIL basic_busy: got %0b expected 1", bus8.busy); end
    for (int i = 0; i < 8; i++) begin
      bus8.bit_in    = pat[7-i];
      bus8.bit_valid = 1'b1;
      step();
      if (i == 6) begin
        tests++; if (bus8.result_valid !== 1'b0) begin fails++; $display("[TB] FAIL basic_early_valid: got %0b expected 0", bus8.result_valid); end
      end
    end
    bus8.bit_valid = 1'b0;
    bus8.bit_in    = 1'b0;
    tests++; if (bus8.result_valid !== 1'b1) begin fails++; $display("[TB] FAIL basic_valid: got %0b expected 1", bus8.result_valid); end
    tests++; if (bus8.result !== 4'd5) begin fails++; $display("[TB] FAIL basic_result: got %0d expected 5", bus8.result); end
    tests++; if (bus8.overflow !== 1'b0) begin fails++; $display("[TB] FAIL basic_ovf: got %0b expected 0", bus8.overflow); end
    tests++; if (bus8.busy !== 1'b0) begin fails++; $display("[TB] FAIL basic_busy_done: got %0b expected 0", bus8.busy); end
    bus8.result_ready = 1'b1;
    step();
    bus8.result_ready = 1'b0;
    tests++; if (bus8.result_valid !== 1'b0 || bus8.busy !== 1'b0) begin fails++; $display("[TB] FAIL basic_idle: got valid=%0b busy=%0b expected 0/0", bus8.result_valid, bus8.busy); end
    tests++; if (bus8.result !== 4'd5) begin fails++; $display("[TB] FAIL basic_result_hold: got %0d expected 5", bus8.result); end
  endtask

  task automatic test_gapped_input();
    logic [7:0] pat;
    int         gap_errs;
    pat      = 8'b1011_0110;
    gap_errs = 0;
    bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus8.bit_in    = pat[7-i];
      bus8.bit_valid = 1'b1;
      step();
      if (i < 7) begin
        if (bus8.busy !== 1'b1 || bus8.result_valid !== 1'b0) gap_errs++;
        bus8.bit_valid = 1'b0;
        bus8.bit_in    = 1'b1;
        step();
        if (bus8.busy !== 1'b1 || bus8.result_valid !== 1'b0) gap_errs++;
      end
    end
    bus8.bit_valid = 1'b0;
    bus8.bit_in    = 1'b0;
    tests++; if (gap_errs !== 0) begin fails++; $display("[TB] FAIL gapped_busy: got %0d bad cycles expected 0", gap_errs); end
    tests++; if (bus8.result_valid !== 1'b1 || bus8.result !== 4'd5) begin fails++; $display("[TB] FAIL gapped_result: got valid=%0b result=%0d expected 1/5", bus8.result_valid, bus8.result); end
    bus8.result_ready = 1'b1;
    step();
    bus8.result_ready = 1'b0;
  endtask

  task automatic test_abort();
    logic [7:0] pat;
    pat = 8'b1111_1111;
    // Abort after four bits.
    bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus8.bit_in    = pat[i];
      bus8.bit_valid = 1'b1;
      step();
    end
    bus8.bit_valid = 1'b0;
    bus8.abort     = 1'b1;
    step();
    bus8.abort = 1'b0;
    tests++; if (bus8.busy !== 1'b0 || bus8.result_valid !== 1'b0) begin fails++; $display("[TB] FAIL abort4_state: got busy=%0b valid=%0b expected 0/0", bus8.busy, bus8.result_valid); end
    tests++; if (bus8.result !== 4'd5) begin fails++; $display("[TB] FAIL abort4_result: got %0d expected 5", bus8.result); end
    // Abort arriving together with the eighth bit.
    bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus8.bit_in    = 1'b1;
      bus8.bit_valid = 1'b1;
      if (i == 7) bus8.abort = 1'b1;
      step();
    end
    bus8.abort     = 1'b0;
    bus8.bit_valid = 1'b0;
    tests++; if (bus8.result_valid !== 1'b0 || bus8.busy !== 1'b0) begin fails++; $display("[TB] FAIL abort8_state: got valid=%0b busy=%0b expected 0/0", bus8.result_valid, bus8.busy); end
    tests++; if (bus8.result !== 4'd5) begin fails++; $display("[TB] FAIL abort8_result: got %0d expected 5", bus8.result); end
    step();
    tests++; if (bus8.result_valid !== 1'b0) begin fails++; $display("[TB] FAIL abort8_late_valid: got %0b expected 0", bus8.result_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pat;
    int         hold_errs;
    pat       = 8'b0110_0111;
    hold_errs = 0;
    bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus8.bit_in    = pat[7-i];
      bus8.bit_valid = 1'b1;
      step();
    end
    bus8.bit_valid = 1'b0;
    // Backpressure: start alone must not leave DONE.
    for (int i = 0; i < 5; i++) begin
      bus8.start = (i == 2);
      step();
      if (bus8.result_valid !== 1'b1 || bus8.result !== 4'd5 || bus8.busy !== 1'b0) hold_errs++;
    end
    tests++; if (hold_errs !== 0) begin fails++; $display("[TB] FAIL backpressure_hold: got %0d bad cycles expected 0", hold_errs); end
    bus8.result_ready = 1'b1;
    bus8.start        = 1'b1;
    step();
    bus8.result_ready = 1'b0;
    bus8.start        = 1'b0;
    tests++; if (bus8.busy !== 1'b1 || bus8.result_valid !== 1'b0) begin fails++; $display("[TB] FAIL b2b_busy: got busy=%0b valid=%0b expected 1/0", bus8.busy, bus8.result_valid); end
    tests++; if (bus8.result !== 4'd5) begin fails++; $display("[TB] FAIL b2b_result_hold: got %0d expected 5", bus8.result); end
    for (int i = 0; i < 8; i++) begin
      bus8.bit_in    = 1'b0;
      bus8.bit_valid = 1'b1;
      step();
    end
    bus8.bit_valid = 1'b0;
    tests++; if (bus8.result_valid !== 1'b1 || bus8.result !== 4'd0) begin fails++; $display("[TB] FAIL b2b_second: got valid=%0b result=%0d expected 1/0", bus8.result_valid, bus8.result); end
    bus8.result_ready = 1'b1;
    step();
    bus8.result_ready = 1'b0;
  endtask

  task automatic test_saturation();
    bus20.start = 1'b1;
    step();
    bus20.start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus20.bit_in    = 1'b1;
      bus20.bit_valid = 1'b1;
      step();
      if (i == 18) begin
        tests++; if (bus20.result_valid !== 1'b0 || bus20.overflow !== 1'b0) begin fails++; $display("[TB] FAIL sat_early: got valid=%0b ovf=%0b expected 0/0", bus20.result_valid, bus20.overflow); end
      end
    end
    bus20.bit_valid = 1'b0;
    tests++; if (bus20.result_valid !== 1'b1 || bus20.result !== 4'd15) begin fails++; $display("[TB] FAIL sat_result: got valid=%0b result=%0d expected 1/15", bus20.result_valid, bus20.result); end
    tests++; if (bus20.overflow !== 1'b1) begin fails++; $display("[TB] FAIL sat_ovf: got %0b expected 1", bus20.overflow); end
    bus20.result_ready = 1'b1;
    step();
    bus20.result_ready = 1'b0;
  endtask

  task automatic test_win1();
    // bit_valid in IDLE must not count or complete anything.
    bus1.bit_in    = 1'b1;
    bus1.bit_valid = 1'b1;
    step();
    step();
    tests++; if (bus1.result_valid !== 1'b0 || bus1.busy !== 1'b0 || bus1.result !== 4'd0) begin fails++; $display("[TB] FAIL win1_idle_ignore: got valid=%0b busy=%0b result=%0d expected 0/0/0", bus1.result_valid, bus1.busy, bus1.result); end
    bus1.bit_valid = 1'b0;
    bus1.start     = 1'b1;
    step();
    bus1.start     = 1'b0;
    bus1.bit_in    = 1'b1;
    bus1.bit_valid = 1'b1;
    step();
    bus1.bit_valid = 1'b0;
    tests++; if (bus1.result_valid !== 1'b1 || bus1.result !== 4'd1) begin fails++; $display("[TB] FAIL win1_result: got valid=%0b result=%0d expected 1/1", bus1.result_valid, bus1.result); end
    bus1.result_ready = 1'b1;
    step();
    bus1.result_ready = 1'b0;
    bus1.start = 1'b1;
    bus1.abort = 1'b1;
    step();
    bus1.start = 1'b0;
    bus1.abort = 1'b0;
    tests++; if (bus1.busy !== 1'b0 || bus1.result_valid !== 1'b0) begin fails++; $display("[TB] FAIL win1_start_abort: got busy=%0b valid=%0b expected 0/0", bus1.busy, bus1.result_valid); end
  endtask

  task automatic test_reset_mid_window();
    bus20.start = 1'b1;
    step();
    bus20.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus20.bit_in    = 1'b1;
      bus20.bit_valid = 1'b1;
      step();
    end
    bus20.bit_valid = 1'b0;
    tests++; if (bus20.busy !== 1'b1 || bus20.result !== 4'd15) begin fails++; $display("[TB] FAIL midrst_pre: got busy=%0b result=%0d expected 1/15", bus20.busy, bus20.result); end
    // Assert reset between edges; outputs must clear without a clock.
    reset = 1'b0;
    #1;
    tests++; if (bus20.busy !== 1'b0 || bus20.result !== 4'd0 || bus20.overflow !== 1'b0 || bus20.result_valid !== 1'b0) begin fails++; $display("[TB] FAIL midrst_async: got busy=%0b result=%0d ovf=%0b valid=%0b expected 0/0/0/0", bus20.busy, bus20.result, bus20.overflow, bus20.result_valid); end
    #1;
    reset = 1'b1;
    step();
    // A fresh window after reset: three ones, no overflow.
    bus20.start = 1'b1;
    step();
    bus20.start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus20.bit_in    = (i < 3);
      bus20.bit_valid = 1'b1;
      step();
    end
    bus20.bit_valid = 1'b0;
    tests++; if (bus20.result_valid !== 1'b1 || bus20.result !== 4'd3) begin fails++; $display("[TB] FAIL post_sat_result: got valid=%0b result=%0d expected 1/3", bus20.result_valid, bus20.result); end
    tests++; if (bus20.overflow !== 1'b0) begin fails++; $display("[TB] FAIL post_sat_ovf: got %0b expected 0", bus20.overflow); end
    bus20.result_ready = 1'b1;
    step();
    bus20.result_ready = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus8.start  = 1'b0; bus8.abort  = 1'b0; bus8.bit_in  = 1'b0; bus8.bit_valid  = 1'b0; bus8.result_ready  = 1'b0;
    bus20.start = 1'b0; bus20.abort = 1'b0; bus20.bit_in = 1'b0; bus20.bit_valid = 1'b0; bus20.result_ready = 1'b0;
    bus1.start  = 1'b0; bus1.abort  = 1'b0; bus1.bit_in  = 1'b0; bus1.bit_valid  = 1'b0; bus1.result_ready  = 1'b0;

    test_reset();
    test_basic_window();
    test_gapped_input();
    test_abort();
    test_back_to_back();
    test_saturation();
    test_win1();
    test_reset_mid_window();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
